// File: rtl/divider_pkg.sv
// Shared definitions for the iterative divider: FSM encoding and operand
// representation selectors.
package divider_pkg;

   // Controller states, in the order a normal division visits them.
   typedef enum logic [2:0] {
      StIdle,
      StPrep,
      StIter,
      StFix,
      StDone
   } div_state_e;

   // Values accepted by the REPRESENTATION parameter (8-character field).
   localparam logic [63:0] REP_UNSIGNED = "UNSIGNED";
   localparam logic [63:0] REP_SIGNED   = {16'h0000, "SIGNED"};

endpackage

// File: rtl/divider_step.sv
// One restoring radix-2 division step: shift the next numerator bit into the
// partial remainder, subtract the divisor if it fits, emit one quotient bit.
module divider_step #(
   parameter int unsigned WIDTHN = 16,
   parameter int unsigned WIDTHD = 16
) (
   input  logic [WIDTHD-1:0] rem_in,
   input  logic [WIDTHN-1:0] num_in,
   input  logic [WIDTHD-1:0] den,
   output logic [WIDTHD-1:0] rem_out,
   output logic [WIDTHN-1:0] num_out
);

   logic [WIDTHD:0] partial;
   logic [WIDTHD:0] diff;
   logic            fits;
   logic            unused_diff_msb;

   // Remainder stays below den, so after a successful subtract the result
   // always fits back into WIDTHD bits and diff's top bit is zero.
   always_comb begin
      partial = {rem_in, num_in[WIDTHN-1]};
      diff    = partial - {1'b0, den};
      fits    = (partial >= {1'b0, den});
      rem_out = fits ? diff[WIDTHD-1:0] : partial[WIDTHD-1:0];
      // Quotient bits shift in from the bottom as numerator bits leave the top.
      num_out = {num_in[WIDTHN-2:0], fits};
   end

   assign unused_diff_msb = diff[WIDTHD];

endmodule

// File: rtl/divider_iterative.sv
// Iterative restoring divider, one quotient bit per enabled cycle, with
// signed/unsigned operands, divide-by-zero and signed-overflow flags.
module divider_iterative
   import divider_pkg::*;
#(
   parameter int unsigned WIDTHN         = 16,
   parameter int unsigned WIDTHD         = 16,
   parameter logic [63:0] REPRESENTATION = REP_UNSIGNED
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clken,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [WIDTHN-1:0] numer,
   input  logic [WIDTHD-1:0] denom,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [WIDTHN-1:0] quotient,
   output logic [WIDTHD-1:0] remain,
   output logic              div_by_zero,
   output logic              overflow
);

   localparam int unsigned       CntW       = $clog2(WIDTHN + 1);
   localparam bit                IsSigned   = (REPRESENTATION == REP_SIGNED);
   localparam logic [CntW-1:0]   LastIter   = CntW'(WIDTHN - 1);
   localparam logic [WIDTHN-1:0] NumMostNeg = {1'b1, {(WIDTHN - 1){1'b0}}};

   div_state_e state_q, state_d;

   logic [CntW-1:0]   cnt_q, cnt_d;
   // num_q holds the raw numerator, then its magnitude, then the quotient.
   logic [WIDTHN-1:0] num_q, num_d;
   logic [WIDTHD-1:0] den_q, den_d;
   logic [WIDTHD-1:0] rem_q, rem_d;
   logic              neg_q, neg_d;
   logic              dz_q, dz_d;
   logic              ovf_q, ovf_d;

   logic [WIDTHN-1:0] quotient_q, quotient_d;
   logic [WIDTHD-1:0] remain_q, remain_d;
   logic              div_by_zero_q, div_by_zero_d;
   logic              overflow_q, overflow_d;

   logic              num_neg;
   logic              den_neg;
   logic [WIDTHD-1:0] step_rem;
   logic [WIDTHN-1:0] step_num;

   assign num_neg = IsSigned & num_q[WIDTHN-1];
   assign den_neg = IsSigned & den_q[WIDTHD-1];

   divider_step #(
      .WIDTHN (WIDTHN),
      .WIDTHD (WIDTHD)
   ) u_step (
      .rem_in  (rem_q),
      .num_in  (num_q),
      .den     (den_q),
      .rem_out (step_rem),
      .num_out (step_num)
   );

   // Next-state and datapath decisions for each FSM state.
   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      num_d         = num_q;
      den_d         = den_q;
      rem_d         = rem_q;
      neg_d         = neg_q;
      dz_d          = dz_q;
      ovf_d         = ovf_q;
      quotient_d    = quotient_q;
      remain_d      = remain_q;
      div_by_zero_d = div_by_zero_q;
      overflow_d    = overflow_q;

      unique case (state_q)
         StIdle: begin
            if (in_valid) begin
               num_d         = numer;
               den_d         = denom;
               div_by_zero_d = 1'b0;
               overflow_d    = 1'b0;
               state_d       = StPrep;
            end
         end
         StPrep: begin
            num_d   = num_neg ? -num_q : num_q;
            den_d   = den_neg ? -den_q : den_q;
            neg_d   = num_neg ^ den_neg;
            dz_d    = (den_q == '0);
            ovf_d   = IsSigned && (num_q == NumMostNeg) && (den_q == '1);
            rem_d   = '0;
            cnt_d   = '0;
            state_d = (den_q == '0) ? StFix : StIter;
         end
         StIter: begin
            num_d = step_num;
            rem_d = step_rem;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LastIter) begin
               state_d = StFix;
            end
         end
         StFix: begin
            if (dz_q) begin
               quotient_d = '1;
               remain_d   = '0;
            end else begin
               // Truncation toward zero: only the quotient takes the sign.
               quotient_d = neg_q ? -num_q : num_q;
               remain_d   = rem_q;
            end
            div_by_zero_d = dz_q;
            overflow_d    = ovf_q;
            state_d       = StDone;
         end
         StDone: begin
            if (out_ready) begin
               state_d = StIdle;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // State register: reset wins over clken, clken low freezes everything.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= StIdle;
         cnt_q         <= '0;
         num_q         <= '0;
         den_q         <= '0;
         rem_q         <= '0;
         neg_q         <= 1'b0;
         dz_q          <= 1'b0;
         ovf_q         <= 1'b0;
         quotient_q    <= '0;
         remain_q      <= '0;
         div_by_zero_q <= 1'b0;
         overflow_q    <= 1'b0;
      end else if (clken) begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         num_q         <= num_d;
         den_q         <= den_d;
         rem_q         <= rem_d;
         neg_q         <= neg_d;
         dz_q          <= dz_d;
         ovf_q         <= ovf_d;
         quotient_q    <= quotient_d;
         remain_q      <= remain_d;
         div_by_zero_q <= div_by_zero_d;
         overflow_q    <= overflow_d;
      end
   end

   assign in_ready    = (state_q == StIdle);
   assign out_valid   = (state_q == StDone);
   assign quotient    = quotient_q;
   assign remain      = remain_q;
   assign div_by_zero = div_by_zero_q;
   assign overflow    = overflow_q;

endmodule

// File: tb/tb_divider_iterative.sv
// Directed bench for divider_iterative: an unsigned and a signed 16/16
// instance share stimulus; each vector checks the instance it targets.
module tb_divider_iterative;
   import divider_pkg::*;

   logic        clk;
   logic        reset;
   logic        clken;
   logic        in_valid;
   logic        out_ready;
   logic [15:0] numer;
   logic [15:0] denom;

   logic        in_ready_u, out_valid_u, dz_u, ov_u;
   logic [15:0] q_u, r_u;
   logic        in_ready_s, out_valid_s, dz_s, ov_s;
   logic [15:0] q_s, r_s;

   logic        sel_s;
   logic        cur_in_ready, cur_out_valid, cur_dz, cur_ov;
   logic [15:0] cur_q, cur_r;

   int checks;
   int failures;

   assign cur_in_ready  = sel_s ? in_ready_s  : in_ready_u;
   assign cur_out_valid = sel_s ? out_valid_s : out_valid_u;
   assign cur_q         = sel_s ? q_s         : q_u;
   assign cur_r         = sel_s ? r_s         : r_u;
   assign cur_dz        = sel_s ? dz_s        : dz_u;
   assign cur_ov        = sel_s ? ov_s        : ov_u;

   divider_iterative #(
      .WIDTHN         (16),
      .WIDTHD         (16),
      .REPRESENTATION (REP_UNSIGNED)
   ) u_dut_u (
      .clk         (clk),
      .reset       (reset),
      .clken       (clken),
      .in_valid    (in_valid),
      .in_ready    (in_ready_u),
      .numer       (numer),
      .denom       (denom),
      .out_valid   (out_valid_u),
      .out_ready   (out_ready),
      .quotient    (q_u),
      .remain      (r_u),
      .div_by_zero (dz_u),
      .overflow    (ov_u)
   );

   divider_iterative #(
      .WIDTHN         (16),
      .WIDTHD         (16),
      .REPRESENTATION (REP_SIGNED)
   ) u_dut_s (
      .clk         (clk),
      .reset       (reset),
      .clken       (clken),
      .in_valid    (in_valid),
      .in_ready    (in_ready_s),
      .numer       (numer),
      .denom       (denom),
      .out_valid   (out_valid_s),
      .out_ready   (out_ready),
      .quotient    (q_s),
      .remain      (r_s),
      .div_by_zero (dz_s),
      .overflow    (ov_s)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        s;
      logic [15:0] n;
      logic [15:0] d;
      logic [15:0] q;
      logic [15:0] r;
      logic        dz;
      logic        ov;
   } vec_t;

   vec_t vecs[10];

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
      end
   endtask

   // Latency counts enabled edges from the accepting edge (counted as 1)
   // through the edge that raises out_valid.
   task automatic run_op(input logic s, input logic [15:0] n, input logic [15:0] d,
                         input bit toggle, input bit consume,
                         output logic [15:0] q, output logic [15:0] r,
                         output logic dz, output logic ov, output int lat);
      int guard;
      sel_s = s;
      clken = 1'b1;
      guard = 0;
      while (!cur_in_ready && guard < 50) begin
         @(posedge clk);
         #1;
         guard++;
      end
      check("in_ready_before_op", 32'(cur_in_ready), 32'd1);
      numer    = n;
      denom    = d;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      lat      = 1;
      guard    = 0;
      while (!cur_out_valid && guard < 200) begin
         if (toggle) clken = ~clken;
         @(posedge clk);
         if (clken) lat++;
         #1;
         guard++;
      end
      clken = 1'b1;
      check("out_valid_seen", 32'(cur_out_valid), 32'd1);
      q  = cur_q;
      r  = cur_r;
      dz = cur_dz;
      ov = cur_ov;
      if (consume) begin
         @(posedge clk);
         #1;
         check("out_valid_after_take", 32'(cur_out_valid), 32'd0);
         check("in_ready_after_take", 32'(cur_in_ready), 32'd1);
      end
   endtask

   initial begin
      logic [15:0] q, r;
      logic        dz, ov;
      int          lat;
      int          stray;

      checks    = 0;
      failures  = 0;
      sel_s     = 1'b0;
      reset     = 1'b1;
      clken     = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      numer     = '0;
      denom     = '0;

      vecs[0] = '{1'b0, 16'd8,     16'd3,     16'd2,     16'd2, 1'b0, 1'b0};
      vecs[1] = '{1'b0, 16'd65535, 16'd3,     16'd21845, 16'd0, 1'b0, 1'b0};
      vecs[2] = '{1'b1, 16'd8,     16'hFFFD,  16'hFFFE,  16'd2, 1'b0, 1'b0};
      vecs[3] = '{1'b1, 16'hFFF3,  16'd3,     16'hFFFC,  16'd1, 1'b0, 1'b0};
      vecs[4] = '{1'b1, 16'hFFF6,  16'hFFFB,  16'd2,     16'd0, 1'b0, 1'b0};
      vecs[5] = '{1'b0, 16'd15,    16'd0,     16'hFFFF,  16'd0, 1'b1, 1'b0};
      vecs[6] = '{1'b0, 16'd9,     16'd4,     16'd2,     16'd1, 1'b0, 1'b0};
      vecs[7] = '{1'b1, 16'h8000,  16'hFFFF,  16'h8000,  16'd0, 1'b0, 1'b1};
      vecs[8] = '{1'b1, 16'd15,    16'd0,     16'hFFFF,  16'd0, 1'b1, 1'b0};
      vecs[9] = '{1'b0, 16'd1000,  16'd7,     16'd142,   16'd6, 1'b0, 1'b0};

      repeat (3) @(posedge clk);
      #1;
      check("rst_in_ready_u", 32'(in_ready_u), 32'd1);
      check("rst_in_ready_s", 32'(in_ready_s), 32'd1);
      check("rst_out_valid_u", 32'(out_valid_u), 32'd0);
      check("rst_out_valid_s", 32'(out_valid_s), 32'd0);
      check("rst_quotient", 32'({q_u, q_s}), 32'd0);
      check("rst_remain", 32'({r_u, r_s}), 32'd0);
      check("rst_flags", 32'({dz_u, ov_u, dz_s, ov_s}), 32'd0);
      reset = 1'b0;

      for (int i = 0; i < 10; i++) begin
         run_op(vecs[i].s, vecs[i].n, vecs[i].d, 1'b0, 1'b1, q, r, dz, ov, lat);
         check($sformatf("v%0d_quotient", i), 32'(q), 32'(vecs[i].q));
         check($sformatf("v%0d_remain", i), 32'(r), 32'(vecs[i].r));
         check($sformatf("v%0d_div_by_zero", i), 32'(dz), 32'(vecs[i].dz));
         check($sformatf("v%0d_overflow", i), 32'(ov), 32'(vecs[i].ov));
         if (!vecs[i].dz) check($sformatf("v%0d_latency", i), 32'(lat), 32'd19);
      end

      // Backpressure: result and flags held while out_ready is low, and new
      // operands offered in the meantime are ignored.
      out_ready = 1'b0;
      run_op(1'b0, 16'd100, 16'd7, 1'b0, 1'b0, q, r, dz, ov, lat);
      check("bp_quotient", 32'(q), 32'd14);
      check("bp_remain", 32'(r), 32'd2);
      check("bp_latency", 32'(lat), 32'd19);
      numer    = 16'd1;
      denom    = 16'd1;
      in_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1;
         check($sformatf("bp%0d_out_valid", i), 32'(out_valid_u), 32'd1);
         check($sformatf("bp%0d_in_ready", i), 32'(in_ready_u), 32'd0);
         check($sformatf("bp%0d_hold", i), 32'({q_u, r_u}), {16'd14, 16'd2});
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      check("bp_release_out_valid", 32'(out_valid_u), 32'd0);
      check("bp_release_in_ready", 32'(in_ready_u), 32'd1);

      // Reset in ITER cycle 5, with clken low to show reset takes priority.
      sel_s    = 1'b0;
      numer    = 16'd200;
      denom    = 16'd3;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      repeat (5) @(posedge clk);
      #1;
      check("pre_reset_busy", 32'(in_ready_u), 32'd0);
      reset = 1'b1;
      clken = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b0;
      clken = 1'b1;
      check("midrst_in_ready", 32'(in_ready_u), 32'd1);
      check("midrst_quotient", 32'(q_u), 32'd0);
      stray = 0;
      for (int i = 0; i < 25; i++) begin
         @(posedge clk);
         #1;
         if (out_valid_u || out_valid_s) stray++;
      end
      check("midrst_no_stale_result", 32'(stray), 32'd0);

      // Fresh op with clken toggling every cycle: latency counts only enabled edges.
      run_op(1'b0, 16'd16, 16'd3, 1'b1, 1'b1, q, r, dz, ov, lat);
      check("toggle_quotient", 32'(q), 32'd5);
      check("toggle_remain", 32'(r), 32'd1);
      check("toggle_latency", 32'(lat), 32'd19);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/divider_iterative.md
DIVIDER_ITERATIVE -- requirements
Module: divider_iterative

Interface
REQ-001 SHALL have parameter WIDTHN, default 16: numerator and quotient width, range 4..64.
REQ-002 SHALL have parameter WIDTHD, default 16: denominator and remainder width, range 4..WIDTHN.
REQ-003 SHALL have parameter REPRESENTATION, default "UNSIGNED": "UNSIGNED" or "SIGNED", applied to both operands.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port clken, input, 1 bit: global clock enable; when low, all state is frozen.
REQ-007 SHALL have port in_valid, input, 1 bit: numer and denom are valid.
REQ-008 SHALL have port in_ready, output, 1 bit: block can accept an operand pair.
REQ-009 SHALL have port numer, input, WIDTHN bits: the numerator.
REQ-010 SHALL have port denom, input, WIDTHD bits: the denominator.
REQ-011 SHALL have port out_valid, output, 1 bit: the result is valid.
REQ-012 SHALL have port out_ready, input, 1 bit: downstream accepts the result.
REQ-013 SHALL have port quotient, output, WIDTHN bits: the quotient.
REQ-014 SHALL have port remain, output, WIDTHD bits: remainder magnitude, always unsigned.
REQ-015 SHALL have port div_by_zero, output, 1 bit: denom was 0.
REQ-016 SHALL have port overflow, output, 1 bit: signed most-negative / -1.

Function
REQ-017 SHALL use the FSM states IDLE -> PREP -> ITER -> FIX -> DONE -> IDLE.
REQ-018 SHALL assert in_ready only in IDLE; a transfer occurs when in_valid & in_ready & clken.
REQ-019 SHALL, in PREP, take absolute values of numer and denom in SIGNED mode and record both operand signs; UNSIGNED mode passes operands through.
REQ-020 SHALL, in ITER, perform restoring radix-2 division at one quotient bit per enabled cycle for exactly WIDTHN cycles, tracked by an iteration counter.
REQ-021 SHALL, in FIX, negate the quotient if the operand signs differ (truncation toward zero); remain stays the magnitude |n| mod |d|.
REQ-022 SHALL assert out_valid in DONE and hold quotient, remain and both flags stable until out_valid & out_ready & clken, then return to IDLE.
REQ-023 SHALL have a latency of exactly WIDTHN+3 enabled cycles from the accepting edge to out_valid high, excluding cycles with clken low.
REQ-024 SHALL achieve a throughput of one result per WIDTHN+4 cycles when out_ready is held high; there is no pipelining.
REQ-025 SHALL, when denom == 0, skip ITER and go to DONE via FIX, with quotient = all ones, remain = 0, div_by_zero = 1.
REQ-026 SHALL, in SIGNED mode with numer = most-negative and denom = -1, set quotient = most-negative, remain = 0, overflow = 1.
REQ-027 SHALL clear both flags on the next accepted operand pair.
REQ-028 SHALL ignore in_valid in every state other than IDLE, with no queuing.
REQ-029 SHALL, when clken is low, freeze state, counter, outputs and handshakes; transfers occur only when clken is high.

Reset
REQ-030 SHALL, on reset high at a clk edge, place the FSM in IDLE and set in_ready=1, out_valid=0, quotient=0, remain=0, div_by_zero=0, overflow=0, iteration counter=0.
REQ-031 SHALL abort any in-flight division on reset mid-operation, with no result emitted afterwards.
REQ-032 SHALL give reset priority over clken.

Structure
REQ-033 SHALL place the FSM state encoding and the REPRESENTATION string constants in the shared package divider_pkg.
REQ-034 SHALL implement the per-cycle shift/compare/subtract step in a sub-module divider_step (combinational, WIDTHD+1-bit compare), instantiated once.
REQ-035 SHALL implement the FSM and iteration counter, sized $clog2(WIDTHN+1), in the top level.

Verification
REQ-036 SHALL verify UNSIGNED, WIDTHN=WIDTHD=16: 8/3 -> q=2, r=2; 65535/3 -> q=21845, r=0; out_valid exactly 19 cycles after accept.
REQ-037 SHALL verify SIGNED: 8/-3 -> q=-2, r=2; -13/3 -> q=-4, r=1; -10/-5 -> q=2, r=0.
REQ-038 SHALL verify 15/0 -> q=16'hFFFF, r=0, div_by_zero=1; the next op 9/4 -> q=2, r=1, div_by_zero=0.
REQ-039 SHALL verify SIGNED -32768/-1 -> q=-32768, r=0, overflow=1.
REQ-040 SHALL verify backpressure: out_ready low for 10 cycles holds out_valid and the result stable, with in_ready=0; the pulse then completes and in_ready returns next cycle.
REQ-041 SHALL verify reset asserted at ITER cycle 5, then clken toggling 50% on a new 16/3: no stale result; q=5, r=1 arrives after 19 enabled cycles.
